reg_file_reader: RTL

Sequential read-out engine for the CPU's 8x8 register file; it is the reader that drives the file's read-address port. On a START pulse it walks register addresses 0..NUM_REGS-1. For each address it waits a settle interval that covers the file's read-path delay, then captures the data. Each captured byte is emitted as a beat on a valid/ready stream for debug dump or context save. It sits beside the register file, sharing one read port with the datapath when the CPU is halted.

---
 rtl/reg_file_reader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/reg_file_reader.sv
// reg_file_reader: walks register-file addresses, waits for the read path to settle, streams each value out.
// Optional REG_FILE_READER_CHECKSUM_EN appends an XOR checksum beat after the last register.
module reg_file_reader #(
  parameter int NUM_REGS      = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  START,
  input  logic                  ABORT,
  output logic [ADDR_WIDTH-1:0] RD_ADDRESS,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic [ADDR_WIDTH-1:0] OUT_ADDR,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  OUT_LAST,
  output logic                  BUSY,
  output logic                  DONE
);
  localparam int CW = SETTLE_CYCLES > 0 ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, SEND, FINISH} state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           counter, counter_n;
  logic [ADDR_WIDTH-1:0]   rd_address_n, out_addr_n;
  logic [DATA_WIDTH-1:0]   out_data_n;
  logic                    out_valid_n, out_last_n, xfer;
`ifdef REG_FILE_READER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]   acc, acc_n;
`endif

  assign xfer = OUT_VALID & OUT_READY;
  assign BUSY = state != IDLE;
  assign DONE = state == FINISH;

  always_comb begin
    state_n      = state;
    counter_n    = counter;
    rd_address_n = RD_ADDRESS;
    out_data_n   = OUT_DATA;
    out_addr_n   = OUT_ADDR;
    out_valid_n  = OUT_VALID;
    out_last_n   = OUT_LAST;
`ifdef REG_FILE_READER_CHECKSUM_EN
    acc_n        = acc;
`endif
    if (ABORT) begin
      state_n      = IDLE;
      rd_address_n = '0;
      out_valid_n  = 1'b0;
      out_last_n   = 1'b0;
    end else begin
      case (state)
        IDLE: if (START) begin
          rd_address_n = '0;
          counter_n    = SETTLE_LOAD;
          state_n      = SETTLE;
`ifdef REG_FILE_READER_CHECKSUM_EN
          acc_n        = '0;
`endif
        end
        SETTLE: if (counter != '0) begin
          counter_n = counter - 1'b1;
        end else begin
          out_data_n  = RD_DATA;
          out_addr_n  = RD_ADDRESS;
          out_valid_n = 1'b1;
`ifdef REG_FILE_READER_CHECKSUM_EN
          out_last_n  = 1'b0;
`else
          out_last_n  = RD_ADDRESS == LAST_ADDR;
`endif
          state_n     = SEND;
        end
        SEND: if (xfer) begin
          out_valid_n = 1'b0;
          out_last_n  = 1'b0;
          if (OUT_LAST) begin
            state_n = FINISH;
`ifdef REG_FILE_READER_CHECKSUM_EN
          end else if (RD_ADDRESS == LAST_ADDR) begin
            // checksum beat goes out immediately; RD_ADDRESS stays parked on the last register
            acc_n       = acc ^ OUT_DATA;
            out_data_n  = acc ^ OUT_DATA;
            out_addr_n  = '0;
            out_valid_n = 1'b1;
            out_last_n  = 1'b1;
`endif
          end else begin
`ifdef REG_FILE_READER_CHECKSUM_EN
            acc_n        = acc ^ OUT_DATA;
`endif
            rd_address_n = RD_ADDRESS + 1'b1;
            counter_n    = SETTLE_LOAD;
            state_n      = SETTLE;
          end
        end
        FINISH: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      counter    <= '0;
      RD_ADDRESS <= '0;
      OUT_DATA   <= '0;
      OUT_ADDR   <= '0;
      OUT_VALID  <= 1'b0;
      OUT_LAST   <= 1'b0;
    end else begin
      state      <= state_n;
      counter    <= counter_n;
      RD_ADDRESS <= rd_address_n;
      OUT_DATA   <= out_data_n;
      OUT_ADDR   <= out_addr_n;
      OUT_VALID  <= out_valid_n;
      OUT_LAST   <= out_last_n;
    end
  end

`ifdef REG_FILE_READER_CHECKSUM_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) acc <= '0;
    else acc <= acc_n;
  end
`endif
endmodule
